// File: rtl/sprite_compositor_pkg.sv
// Shared constants for the sprite compositor: default parameters,
// background tile-to-sheet-cell mapping and the power-up palette.
package sprite_compositor_pkg;

  localparam int DEF_TILE_PX = 40;
  localparam int DEF_SHEET_W = 200;
  localparam int DEF_NUM_SPR = 2;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_IDX_W   = 4;
  localparam int DEF_KEY_IDX = 13;

  typedef struct packed {
    logic [2:0] cx;
    logic [2:0] cy;
  } cell_t;

  localparam cell_t BORDER_CELL = '{cx: 3'd0, cy: 3'd4};

  localparam logic [23:0] DEF_PALETTE [16] = '{
    24'h0AB1FF, 24'hFF3118, 24'hFFC6B5, 24'h9C4A00,
    24'hE75A10, 24'hC66300, 24'hD65A00, 24'hF7D6B5,
    24'hFF945A, 24'hE69C21, 24'hBDFF18, 24'h00AD00,
    24'h000000, 24'hFF00FF, 24'hFF00FF, 24'hFF00FF
  };

  // Sheet cell holding the artwork for a background block ID.
  function automatic cell_t tile_cell(input logic [2:0] id);
    case (id)
      3'd0:    return '{cx: 3'd4, cy: 3'd4};
      3'd1:    return '{cx: 3'd2, cy: 3'd3};
      3'd2:    return '{cx: 3'd0, cy: 3'd2};
      3'd3:    return '{cx: 3'd1, cy: 3'd3};
      3'd4:    return '{cx: 3'd1, cy: 3'd2};
      3'd5:    return '{cx: 3'd2, cy: 3'd2};
      3'd6:    return '{cx: 3'd3, cy: 3'd3};
      default: return '{cx: 3'd4, cy: 3'd3};
    endcase
  endfunction

  // Power-up colour of a palette entry; entries past the table read as key magenta.
  function automatic logic [23:0] default_color(input int i);
    if (i < 16) return DEF_PALETTE[i[3:0]];
    return 24'hFF00FF;
  endfunction

endpackage

// File: rtl/sprite_compositor_sheet_addr_gen.sv
// Combinational sheet-ROM address for one pixel inside one sheet cell.
// All arithmetic is carried at ADDR_W bits, which gives the same result as
// computing at full width and truncating.
module sheet_addr_gen
  import sprite_compositor_pkg::*;
#(
  parameter int TILE_PX = DEF_TILE_PX,
  parameter int SHEET_W = DEF_SHEET_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [2:0]        cx,
  input  logic [2:0]        cy,
  input  logic              flip,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [9:0] TILE_W  = 10'(TILE_PX);
  localparam logic [9:0] TILE_M1 = 10'(TILE_PX - 1);

  logic [9:0] px;
  logic [9:0] py;

  // Offset within the cell (mirrored horizontally on flip), then cell base.
  always_comb begin
    px = draw_x % TILE_W;
    if (flip) px = TILE_M1 - px;
    py = draw_y % TILE_W;
    addr = ADDR_W'(SHEET_W * TILE_PX) * ADDR_W'(cy)
         + ADDR_W'(TILE_PX) * ADDR_W'(cx)
         + ADDR_W'(px)
         + ADDR_W'(SHEET_W) * ADDR_W'(py);
  end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage pixel compositor: layer select + ROM addressing, index
// merge with colour-key transparency, palette lookup.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int TILE_PX = DEF_TILE_PX,
  parameter int SHEET_W = DEF_SHEET_W,
  parameter int NUM_SPR = DEF_NUM_SPR,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int IDX_W   = DEF_IDX_W,
  parameter logic [IDX_W-1:0] KEY_IDX = IDX_W'(DEF_KEY_IDX)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    pix_valid,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    border,
  input  logic [2:0]              tile_id,
  input  logic [NUM_SPR-1:0]      spr_hit,
  input  logic [NUM_SPR-1:0][2:0] spr_cx,
  input  logic [NUM_SPR-1:0][2:0] spr_cy,
  input  logic [NUM_SPR-1:0]      spr_flip,
  output logic [ADDR_W-1:0]       spr_addr,
  output logic [ADDR_W-1:0]       tile_addr,
  input  logic [IDX_W-1:0]        spr_idx,
  input  logic [IDX_W-1:0]        tile_idx,
  input  logic                    pal_we,
  input  logic [IDX_W-1:0]        pal_waddr,
  input  logic [23:0]             pal_wdata,
  output logic                    rgb_valid,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B
);

  localparam int PAL_N = 2 ** IDX_W;

  logic              win_hit;
  logic [2:0]        win_cx;
  logic [2:0]        win_cy;
  logic              win_flip;
  cell_t             tcell;
  logic [ADDR_W-1:0] spr_addr_c;
  logic [ADDR_W-1:0] tile_addr_c;
  logic              v1, hit1, v2, hit2;
  logic [IDX_W-1:0]  final_idx;
  logic [23:0]       pal [PAL_N];

  // Lowest-index hitting layer wins; scan from the top so it overwrites the rest.
  always_comb begin
    win_hit  = 1'b0;
    win_cx   = spr_cx[0];
    win_cy   = spr_cy[0];
    win_flip = spr_flip[0];
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (spr_hit[i]) begin
        win_hit  = 1'b1;
        win_cx   = spr_cx[i];
        win_cy   = spr_cy[i];
        win_flip = spr_flip[i];
      end
    end
    tcell = border ? BORDER_CELL : tile_cell(tile_id);
  end

  sheet_addr_gen #(.TILE_PX(TILE_PX), .SHEET_W(SHEET_W), .ADDR_W(ADDR_W)) u_spr_addr (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .cx     (win_cx),
    .cy     (win_cy),
    .flip   (win_flip),
    .addr   (spr_addr_c)
  );

  sheet_addr_gen #(.TILE_PX(TILE_PX), .SHEET_W(SHEET_W), .ADDR_W(ADDR_W)) u_tile_addr (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .cx     (tcell.cx),
    .cy     (tcell.cy),
    .flip   (1'b0),
    .addr   (tile_addr_c)
  );

  // Stages 1 and 2: ROM addresses out, qualifiers follow the ROM latency.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1        <= 1'b0;
      hit1      <= 1'b0;
      spr_addr  <= '0;
      tile_addr <= '0;
      v2        <= 1'b0;
      hit2      <= 1'b0;
    end else begin
      v1        <= pix_valid;
      hit1      <= win_hit;
      spr_addr  <= win_hit ? spr_addr_c : '0;
      tile_addr <= tile_addr_c;
      v2        <= v1;
      hit2      <= hit1;
    end
  end

  // A keyed sprite pixel shows the background, never a lower layer.
  always_comb begin
    final_idx = (hit2 && (spr_idx != KEY_IDX)) ? spr_idx : tile_idx;
  end

  // Stage 3: palette lookup; blank colour whenever no pixel is in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_valid <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else if (v2) begin
      rgb_valid             <= 1'b1;
      {VGA_R, VGA_G, VGA_B} <= pal[final_idx];
    end else begin
      rgb_valid <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end
  end

  // Palette registers: defaults on reset, writes land on the following cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < PAL_N; i++) pal[i] <= default_color(i);
    end else if (pal_we) begin
      pal[pal_waddr] <= pal_wdata;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with behavioural 1-cycle sheet ROMs.
module tb_sprite_compositor;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             pix_valid;
  logic [9:0]       DrawX, DrawY;
  logic             border;
  logic [2:0]       tile_id;
  logic [1:0]       spr_hit;
  logic [1:0][2:0]  spr_cx, spr_cy;
  logic [1:0]       spr_flip;
  logic [15:0]      spr_addr, tile_addr;
  logic [3:0]       spr_idx, tile_idx;
  logic             pal_we;
  logic [3:0]       pal_waddr;
  logic [23:0]      pal_wdata;
  logic             rgb_valid;
  logic [7:0]       VGA_R, VGA_G, VGA_B;

  logic [3:0] spr_rom  [65536];
  logic [3:0] tile_rom [65536];

  int checks = 0;
  int errors = 0;

  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .border(border), .tile_id(tile_id), .spr_hit(spr_hit), .spr_cx(spr_cx),
    .spr_cy(spr_cy), .spr_flip(spr_flip), .spr_addr(spr_addr), .tile_addr(tile_addr),
    .spr_idx(spr_idx), .tile_idx(tile_idx), .pal_we(pal_we), .pal_waddr(pal_waddr),
    .pal_wdata(pal_wdata), .rgb_valid(rgb_valid), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B)
  );

  always #5 Clk = ~Clk;

  // Sheet ROMs with one cycle of read latency.
  always @(posedge Clk) begin
    spr_idx  <= spr_rom[spr_addr];
    tile_idx <= tile_rom[tile_addr];
  end

  task automatic idle();
    pix_valid = 1'b0;
    border    = 1'b0;
    tile_id   = 3'd0;
    spr_hit   = 2'b00;
    spr_cx    = '0;
    spr_cy    = '0;
    spr_flip  = 2'b00;
    pal_we    = 1'b0;
    pal_waddr = 4'd0;
    pal_wdata = 24'd0;
    DrawX     = 10'd0;
    DrawY     = 10'd0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle();
    repeat (2) @(negedge Clk);
    checks++;
    if ({spr_addr, tile_addr} !== 32'd0) begin
      errors++; $display("FAIL reset_addr got %h/%h want 0/0", spr_addr, tile_addr);
    end
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== 25'd0) begin
      errors++; $display("FAIL reset_rgb got v=%b %h%h%h want 0 000000", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (rgb_valid !== 1'b0) begin
      errors++; $display("FAIL idle_valid got %b want 0", rgb_valid);
    end
  endtask

  // tile 1 -> cell (2,3); px=py=5: 8000*3 + 40*2 + 5 + 200*5 = 25085
  task automatic test_tile_only();
    tile_rom[25085] = 4'h3;
    @(negedge Clk); idle();
    pix_valid = 1'b1; DrawX = 10'd125; DrawY = 10'd45; tile_id = 3'd1;
    @(negedge Clk); pix_valid = 1'b0;
    checks++;
    if (tile_addr !== 16'd25085) begin
      errors++; $display("FAIL tile_addr got %0d want 25085", tile_addr);
    end
    checks++;
    if (spr_addr !== 16'd0) begin
      errors++; $display("FAIL miss_spr_addr got %0d want 0", spr_addr);
    end
    @(negedge Clk);
    checks++;
    if (rgb_valid !== 1'b0) begin
      errors++; $display("FAIL early_valid got %b want 0", rgb_valid);
    end
    @(negedge Clk);
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h9C4A00}) begin
      errors++; $display("FAIL tile_rgb got v=%b %h%h%h want 1 9C4A00", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
    @(negedge Clk);
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== 25'd0) begin
      errors++; $display("FAIL blank_after got v=%b %h%h%h want 0 000000", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
  endtask

  // layer0 (1,0) flipped at x=0 -> px=39: 40+39 = 79; layer1 would be 16120
  task automatic test_priority_flip();
    spr_rom[79] = 4'h5; spr_rom[16120] = 4'h2; tile_rom[32160] = 4'h7;
    @(negedge Clk); idle();
    pix_valid = 1'b1; spr_hit = 2'b11;
    spr_cx[0] = 3'd1; spr_cy[0] = 3'd0; spr_flip[0] = 1'b1;
    spr_cx[1] = 3'd3; spr_cy[1] = 3'd2; spr_flip[1] = 1'b0;
    @(negedge Clk); idle();
    checks++;
    if (spr_addr !== 16'd79) begin
      errors++; $display("FAIL prio_spr_addr got %0d want 79", spr_addr);
    end
    checks++;
    if (tile_addr !== 16'd32160) begin
      errors++; $display("FAIL prio_tile_addr got %0d want 32160", tile_addr);
    end
    repeat (2) @(negedge Clk);
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'hC66300}) begin
      errors++; $display("FAIL prio_rgb got v=%b %h%h%h want 1 C66300", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
  endtask

  // layer1 (3,2), x=13 y=82: 16000+120+13+400 = 16533; flipped px=26 -> 16546
  task automatic test_layer1_flip();
    spr_rom[16533] = 4'h8; spr_rom[16546] = 4'h9;
    @(negedge Clk); idle();
    pix_valid = 1'b1; spr_hit = 2'b10; DrawX = 10'd13; DrawY = 10'd82;
    spr_cx[1] = 3'd3; spr_cy[1] = 3'd2; spr_flip[1] = 1'b0;
    @(negedge Clk);
    spr_flip[1] = 1'b1;
    checks++;
    if (spr_addr !== 16'd16533) begin
      errors++; $display("FAIL l1_addr got %0d want 16533", spr_addr);
    end
    @(negedge Clk); idle();
    checks++;
    if (spr_addr !== 16'd16546) begin
      errors++; $display("FAIL l1_flip_addr got %0d want 16546", spr_addr);
    end
    @(negedge Clk);
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'hFF945A}) begin
      errors++; $display("FAIL l1_rgb got v=%b %h%h%h want 1 FF945A", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
    @(negedge Clk);
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'hE69C21}) begin
      errors++; $display("FAIL l1_flip_rgb got v=%b %h%h%h want 1 E69C21", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
  endtask

  // keyed layer0 over opaque layer1 (2,1 -> 8080) must show tile 2 (0,2 -> 16000)
  task automatic test_transparency();
    spr_rom[0] = 4'hD; spr_rom[8080] = 4'h1; tile_rom[16000] = 4'h0;
    @(negedge Clk); idle();
    pix_valid = 1'b1; spr_hit = 2'b11; tile_id = 3'd2;
    spr_cx[1] = 3'd2; spr_cy[1] = 3'd1;
    @(negedge Clk); idle();
    checks++;
    if (tile_addr !== 16'd16000) begin
      errors++; $display("FAIL key_tile_addr got %0d want 16000", tile_addr);
    end
    repeat (2) @(negedge Clk);
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h0AB1FF}) begin
      errors++; $display("FAIL key_rgb got v=%b %h%h%h want 1 0AB1FF", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
  endtask

  // border -> (0,4), x=7 y=41: 32000+7+200 = 32207
  task automatic test_border();
    tile_rom[32207] = 4'hA;
    @(negedge Clk); idle();
    pix_valid = 1'b1; border = 1'b1; tile_id = 3'd5; DrawX = 10'd7; DrawY = 10'd41;
    @(negedge Clk); idle();
    checks++;
    if (tile_addr !== 16'd32207) begin
      errors++; $display("FAIL border_addr got %0d want 32207", tile_addr);
    end
    repeat (2) @(negedge Clk);
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'hBDFF18}) begin
      errors++; $display("FAIL border_rgb got v=%b %h%h%h want 1 BDFF18", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
  endtask

  // Write lands on the same edge pixel A is looked up; pixel B sees it.
  task automatic test_palette_write();
    @(negedge Clk); idle();
    pix_valid = 1'b1; tile_id = 3'd2;
    @(negedge Clk);
    @(negedge Clk);
    pix_valid = 1'b0; pal_we = 1'b1; pal_waddr = 4'd0; pal_wdata = 24'h123456;
    @(negedge Clk);
    pal_we = 1'b0;
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h0AB1FF}) begin
      errors++; $display("FAIL pal_old got v=%b %h%h%h want 1 0AB1FF", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
    @(negedge Clk);
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h123456}) begin
      errors++; $display("FAIL pal_new got v=%b %h%h%h want 1 123456", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
  endtask

  task automatic test_back_to_back();
    int cnt = 0, first = -1, last = -1, bad_rgb = 0;
    @(negedge Clk); idle();
    tile_id = 3'd2;
    for (int k = 0; k < 106; k++) begin
      if (k > 0) @(negedge Clk);
      if (rgb_valid === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h123456) bad_rgb++;
      end
      pix_valid = (k < 100);
    end
    checks++;
    if (cnt !== 100 || first !== 3 || last !== 102) begin
      errors++; $display("FAIL stream got cnt=%0d first=%0d last=%0d want 100/3/102", cnt, first, last);
    end
    checks++;
    if (bad_rgb !== 0) begin
      errors++; $display("FAIL stream_rgb got %0d wrong colours want 0", bad_rgb);
    end
  endtask

  task automatic test_reset_midstream();
    int stray = 0;
    @(negedge Clk); idle();
    tile_id = 3'd2;
    for (int k = 0; k <= 50; k++) begin
      @(negedge Clk);
      pix_valid = 1'b1;
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B, spr_addr, tile_addr} !== 57'd0) begin
      errors++; $display("FAIL midreset_out got v=%b rgb=%h%h%h a=%0d/%0d want all 0",
                         rgb_valid, VGA_R, VGA_G, VGA_B, spr_addr, tile_addr);
    end
    @(negedge Clk);
    pix_valid = 1'b0; Reset = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      if (rgb_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL inflight_dropped got %0d valid cycles want 0", stray);
    end
    pix_valid = 1'b1;
    @(negedge Clk); pix_valid = 1'b0;
    @(negedge Clk);
    checks++;
    if (rgb_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_early got %b want 0", rgb_valid);
    end
    @(negedge Clk);
    checks++;
    if ({rgb_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h0AB1FF}) begin
      errors++; $display("FAIL pal_restored got v=%b %h%h%h want 1 0AB1FF", rgb_valid, VGA_R, VGA_G, VGA_B);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      spr_rom[a]  = 4'hE;
      tile_rom[a] = 4'hC;
    end
    test_reset();
    test_tile_only();
    test_priority_flip();
    test_layer1_flip();
    test_transparency();
    test_border();
    test_palette_write();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
